// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the two-requester SRAM arbiter.
package sram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes plus SRAM-side signals for sram_arbiter.
interface sram_arbiter_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              ack_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_b;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_dout,
    input  ack_a, ack_b, rdata, busy,
    input  mem_en, mem_addr, mem_din
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_dout,
    output ack_a, ack_b, rdata, busy,
    output mem_en, mem_addr, mem_din
  );

endinterface

// File: rtl/rr_arbiter.sv
// Two-way arbiter: one-hot grant (bit 0 = A). Round-robin pointer exists only
// when SRAM_ARB_RR_EN is defined; otherwise A always wins a tie.
module rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  input  logic       i_winner_b,
  output logic [1:0] o_grant
);

`ifdef SRAM_ARB_RR_EN
  logic r_ptr_b;

  // Pointer moves to the requester that did not win the completed transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr_b <= 1'b0;
    end else if (i_advance) begin
      r_ptr_b <= ~i_winner_b;
    end
  end

  always_comb begin
    o_grant = '0;
    if (r_ptr_b) begin
      if (i_req[1])      o_grant = 2'b10;
      else if (i_req[0]) o_grant = 2'b01;
    end else begin
      if (i_req[0])      o_grant = 2'b01;
      else if (i_req[1]) o_grant = 2'b10;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, reset, i_advance, i_winner_b};

  always_comb begin
    o_grant = '0;
    if (i_req[0])      o_grant = 2'b01;
    else if (i_req[1]) o_grant = 2'b10;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one synchronous SRAM port (1-cycle read latency).
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority to A.
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  logic              r_win_b;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ack_a;
  logic              r_ack_b;

  logic [1:0]        w_grant;
  logic              w_start;
  logic              w_done;

  rr_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_req      ({bus.req_b, bus.req_a}),
    .i_advance  (w_done),
    .i_winner_b (r_win_b),
    .o_grant    (w_grant)
  );

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_start = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_we) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else begin
          w_next = RDWAIT;
        end
      end
      RDWAIT: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Ack is registered, so it is visible in the IDLE cycle that follows completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_win_b <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack_a <= w_done & ~r_win_b;
      r_ack_b <= w_done &  r_win_b;
      if (w_start) begin
        r_win_b <= w_grant[1];
        r_we    <= w_grant[1] ? bus.we_b    : bus.we_a;
        r_addr  <= w_grant[1] ? bus.addr_b  : bus.addr_a;
        r_wdata <= w_grant[1] ? bus.wdata_b : bus.wdata_a;
      end
      if (r_state == RDWAIT) begin
        r_rdata <= bus.mem_dout;
      end
    end
  end

  assign bus.ack_a    = r_ack_a;
  assign bus.ack_b    = r_ack_b;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = (r_state != IDLE);
  assign bus.mem_en   = (r_state == ACCESS) & r_we;
  assign bus.mem_addr = (r_state == ACCESS) ? r_addr  : '0;
  assign bus.mem_din  = (r_state == ACCESS) ? r_wdata : '0;

endmodule
